bit_serial_adder_sequencer: RTL and testbench
=============================================

Name: bit_serial_adder_sequencer

Overview:
Sequences one single_bit_full_adder instance over a WIDTH-bit operand pair, LSB first, one bit per clock, so that a multi-bit add/subtract needs only one adder cell.
- Owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.
- Sits in the ALU as the low-area add/sub path beside the parallel logic units.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- input_clock  in  1  rising-edge clock.
- input_reset_n  in  1  synchronous reset, active-low, sampled on input_clock.
- input_start  in  1  request a new operation; accepted only in IDLE.
- input_subtract  in  1  0 = A+B, 1 = A-B; captured with start.
- input_a  in  WIDTH  operand A; captured with start.
- input_b  in  WIDTH  operand B; captured with start.
- output_busy  out  1  high in RUN and DONE.
- output_done  out  1  one-cycle pulse in DONE.
- output_sum  out  WIDTH  result; held until the next completion.
- output_carry  out  1  final carry-out (for subtract, 1 = no borrow).
- output_overflow  out  1  signed two's-complement overflow.

Behaviour:
- Reset (input_reset_n = 0 at an edge): state goes to IDLE, and all of the following clear to 0: counter, carry FF, operand registers, output_busy, output_done, output_sum, output_carry, output_overflow. Reset wins over every other input, including mid-RUN; the partial result is discarded.
- State IDLE:
  - If input_start = 1, capture A into shift register SA.
  - Capture B into SB; if input_subtract = 1, capture ~B instead.
  - Load the carry FF with input_subtract.
  - Clear the counter and go to RUN.
  - If input_start = 0, stay in IDLE.
- State RUN, per edge:
  - The adder cell sees input_a = SA[0], input_b = SB[0], input_carry = carry FF.
  - The adder's output_sum shifts into the MSB of result register SR; SR, SA and SB shift right by 1.
  - The carry FF takes the adder's output_carry.
  - Counter increments. At the edge where counter = WIDTH-1, the final bit is processed and the state goes to DONE.
  - The last processed bit must save the carry-in to the MSB stage for the overflow calculation.
- State DONE (exactly one cycle):
  - output_done = 1.
  - output_sum = SR, output_carry = final carry, output_overflow = carry-in(MSB) XOR carry-out(MSB). These were registered at the entry edge.
  - Next edge goes to IDLE.
- Latency: with start captured at edge k, output_done is high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- output_busy = 1 in RUN and DONE, 0 in IDLE; combinational from state.
- input_start while busy (RUN or DONE) is ignored, not queued. Operand or subtract changes while busy have no effect.
- output_sum, output_carry and output_overflow change only on DONE entry or reset, and stay stable through the next operation until its DONE.
- Arithmetic is modulo 2^WIDTH. Subtract is A + ~B + 1.
- The result registers and the adder cell hold no state beyond what is listed above; the adder is purely combinational.

Test Plan:
- WIDTH=8: start, A=0x35, B=0x4A, add -> output_done high exactly 8 edges after the start edge (busy 9 cycles); sum=0x7F, carry=0, overflow=0.
- A=0xFF, B=0x01, add -> sum=0x00, carry=1, overflow=0. Then A=0x7F, B=0x01 -> sum=0x80, carry=0, overflow=1.
- Subtract: A=0x05, B=0x07 -> sum=0xFE, carry=0, overflow=0. Then A=0x80, B=0x01 -> sum=0x7F, carry=1, overflow=1.
- Start A=0x10, B=0x20; pulse input_start with A=0xAA, B=0x55 at edge 3 and in the DONE cycle -> only one done pulse, sum=0x30, busy drops after DONE.
- Complete 0x01+0x01 (sum=0x02). Start 0x0F+0x01, then drive input_reset_n=0 at edge 4 -> next cycle busy=0, done=0, sum=0x00. A fresh 0x03+0x04 then gives sum=0x07 with no stale carry.
- Back-to-back: start asserted continuously -> a new operation is accepted every WIDTH+2 = 10 cycles; each done pulse is exactly 1 cycle wide.

Source files
------------

// File: rtl/bit_serial_adder_sequencer.sv
// Bit-serial add/sub sequencer: one full-adder cell stepped LSB first
// over a WIDTH-bit operand pair, one bit per clock.
module bit_serial_adder_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             input_clock,
  input  logic             input_reset_n,
  input  logic             input_start,
  input  logic             input_subtract,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             output_busy,
  output logic             output_done,
  output logic [WIDTH-1:0] output_sum,
  output logic             output_carry,
  output logic             output_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] sa, sb, sr;
  logic [CNT_W-1:0] cnt;
  logic             cff;
  logic             fa_sum, fa_carry;
  logic             last;

  single_bit_full_adder u_fa (
    .input_a     (sa[0]),
    .input_b     (sb[0]),
    .input_carry (cff),
    .output_sum  (fa_sum),
    .output_carry(fa_carry)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge input_clock) begin
    if (!input_reset_n) state <= IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (input_start) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign output_busy = (state != IDLE);
  assign output_done = (state == DONE);

  // Overflow uses the carry FF as the carry into the MSB on the last step.
  always_ff @(posedge input_clock) begin
    if (!input_reset_n) begin
      sa              <= '0;
      sb              <= '0;
      sr              <= '0;
      cnt             <= '0;
      cff             <= 1'b0;
      output_sum      <= '0;
      output_carry    <= 1'b0;
      output_overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (input_start) begin
            sa  <= input_a;
            sb  <= input_subtract ? ~input_b : input_b;
            cff <= input_subtract;
            cnt <= '0;
          end
        end
        RUN: begin
          sr  <= {fa_sum, sr[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cff <= fa_carry;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            output_sum      <= {fa_sum, sr[WIDTH-1:1]};
            output_carry    <= fa_carry;
            output_overflow <= cff ^ fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

module single_bit_full_adder (
  input  logic input_a,
  input  logic input_b,
  input  logic input_carry,
  output logic output_sum,
  output logic output_carry
);
  assign output_sum   = input_a ^ input_b ^ input_carry;
  assign output_carry = (input_a & input_b) |
                        (input_carry & (input_a ^ input_b));
endmodule

// File: tb/tb_bit_serial_adder_sequencer.sv
// Bench for bit_serial_adder_sequencer: directed and random add/sub
// checked against an arithmetic reference model.
module tb_bit_serial_adder_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         carry, ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] prev_sum;

  bit_serial_adder_sequencer #(.WIDTH(W)) dut (
    .input_clock    (clk),
    .input_reset_n  (rst_n),
    .input_start    (start),
    .input_subtract (sub),
    .input_a        (a),
    .input_b        (b),
    .output_busy    (busy),
    .output_done    (done),
    .output_sum     (sum),
    .output_carry   (carry),
    .output_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {carry, overflow, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic s);
    int unsigned xi, yi, full;
    int sx, sy, sres;
    logic [W-1:0] r;
    logic c, o;
    xi = int'(x);
    yi = int'(y);
    sx = (xi >= (1 << (W - 1))) ? int'(xi) - (1 << W) : int'(xi);
    sy = (yi >= (1 << (W - 1))) ? int'(yi) - (1 << W) : int'(yi);
    if (s) begin
      full = xi + ((1 << W) - yi);
      sres = sx - sy;
    end else begin
      full = xi + yi;
      sres = sx + sy;
    end
    r = W'(full % (1 << W));
    c = (full >= (1 << W));
    o = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
    return {c, o, r};
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input string tag);
    logic [W+1:0] e;
    int lat, busy_n;
    e = ref_model(x, y, s);
    start = 1'b1;
    a = x;
    b = y;
    sub = s;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    check({tag, "_held"}, 32'(sum), 32'(prev_sum));
    lat = 0;
    busy_n = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (busy) busy_n++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(W));
    check({tag, "_busyn"}, 32'(busy_n), 32'(W + 1));
    check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
    check({tag, "_carry"}, 32'(carry), 32'(e[W+1]));
    check({tag, "_ovf"}, 32'(ovf), 32'(e[W]));
    tick();
    check({tag, "_donew"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    prev_sum = e[W-1:0];
  endtask

  initial begin
    logic [W+1:0] e;
    int cnt, dn, cyc, lastc, ops;

    rst_n = 1'b0;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    prev_sum = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    do_op(8'h35, 8'h4A, 1'b0, "add35");
    do_op(8'hFF, 8'h01, 1'b0, "addFF");
    do_op(8'h7F, 8'h01, 1'b0, "add7F");
    do_op(8'h05, 8'h07, 1'b1, "sub05");
    do_op(8'h80, 8'h01, 1'b1, "sub80");

    // start pulses while busy must be ignored
    start = 1'b1;
    a = 8'h10;
    b = 8'h20;
    sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    tick();
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 40) begin
      tick();
      cnt++;
    end
    check("ign_done", 32'(done), 32'd1);
    check("ign_sum", 32'(sum), 32'h30);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) dn++;
    end
    check("ign_extra", 32'(dn), 32'd0);
    check("ign_held", 32'(sum), 32'h30);
    prev_sum = 8'h30;

    // reset mid-run discards the partial result
    do_op(8'h01, 8'h01, 1'b0, "pre_rst");
    start = 1'b1;
    a = 8'h0F;
    b = 8'h01;
    sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_sum", 32'(sum), 32'd0);
    prev_sum = '0;
    tick();
    do_op(8'h03, 8'h04, 1'b0, "post_rst");

    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), "rnd");

    // back-to-back with start held high
    start = 1'b1;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    e = ref_model(a, b, sub);
    cyc = 0;
    lastc = -1;
    ops = 0;
    while (ops < 4 && cyc < 200) begin
      tick();
      cyc++;
      if (done) begin
        check("b2b_sum", 32'(sum), 32'(e[W-1:0]));
        check("b2b_carry", 32'(carry), 32'(e[W+1]));
        check("b2b_ovf", 32'(ovf), 32'(e[W]));
        if (lastc >= 0)
          check("b2b_period", 32'(cyc - lastc), 32'(W + 2));
        lastc = cyc;
        ops++;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
        e = ref_model(a, b, sub);
        tick();
        cyc++;
        check("b2b_donew", 32'(done), 32'd0);
      end
    end
    check("b2b_ops", 32'(ops), 32'd4);
    start = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
